fetch_unit: RTL and testbench

//  Instruction-fetch stage directly downstream of PC_Updater: consumes its OutAddr, reads the
//  16-bit instruction from a variable-latency instruction memory (req/valid handshake) and loads
//  the IF/ID pipeline register. Pulses pc_advance to let PC_Updater step; honours decode stall,

---
 rtl/fetch_unit_pkg.sv | 20 ++
 rtl/fetch_unit.sv | 163 ++++++++++++++++
 tb/tb_fetch_unit.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, instruction/address
// widths and the default HALT opcode / NOP instruction values. Imported by
// fetch_unit and usable by neighbouring pipeline stages.
package fetch_unit_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned ADDR_W  = 16;

    localparam logic [3:0]         HALT_OP_DEFAULT   = 4'hF;
    localparam logic [INSTR_W-1:0] NOP_INSTR_DEFAULT = 16'h0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_HOLD,
        ST_HALT
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage. Takes the current PC, issues a single-outstanding
// read to a variable-latency instruction memory, and loads the IF/ID pipeline
// register. Honours decode stall, branch flush and HALT.
//
// Ports:
//   clk            clock, all state updates on posedge
//   rst            synchronous active-low reset
//   pc_in          current PC from the PC updater
//   stall          decode cannot accept; IF/ID holds
//   flush          branch taken; discard IF/ID and any in-flight fetch
//   mem_rdata      instruction memory read data
//   mem_valid      mem_rdata valid (response to last mem_req)
//   mem_req        one-cycle read request
//   mem_addr       registered read address
//   pc_advance     one-cycle pulse: instruction accepted, PC may step
//   if_id_instr    IF/ID instruction
//   if_id_pc_plus2 IF/ID fetch address + 2
//   if_id_valid    IF/ID holds a real instruction
//   halted         HALT fetched; no further requests
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [3:0]         HALT_OP   = HALT_OP_DEFAULT,
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  pc_in,
    input  logic               stall,
    input  logic               flush,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               mem_valid,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               pc_advance,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [ADDR_W-1:0]  if_id_pc_plus2,
    output logic               if_id_valid,
    output logic               halted
);

    fetch_state_t       state, state_d;
    logic               squash, squash_d;
    logic [INSTR_W-1:0] hold_instr, hold_instr_d;
    logic [ADDR_W-1:0]  hold_pc2, hold_pc2_d;

    logic               mem_req_d;
    logic [ADDR_W-1:0]  mem_addr_d;
    logic               pc_advance_d;
    logic [INSTR_W-1:0] instr_d;
    logic [ADDR_W-1:0]  pc2_d;
    logic               valid_d;
    logic               halted_d;

    logic               accept;
    logic [INSTR_W-1:0] acc_instr;
    logic [ADDR_W-1:0]  acc_pc2;

    always_comb begin
        state_d      = state;
        squash_d     = squash;
        hold_instr_d = hold_instr;
        hold_pc2_d   = hold_pc2;
        mem_req_d    = 1'b0;
        mem_addr_d   = mem_addr;
        pc_advance_d = 1'b0;
        instr_d      = if_id_instr;
        pc2_d        = if_id_pc_plus2;
        valid_d      = if_id_valid;
        halted_d     = halted;
        accept       = 1'b0;
        acc_instr    = hold_instr;
        acc_pc2      = hold_pc2;

        unique case (state)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
                // The request goes out on this edge regardless of flush, so a
                // flush here must mark the response for discard.
                mem_req_d  = 1'b1;
                mem_addr_d = pc_in;
                state_d    = ST_WAIT;
                if (flush) squash_d = 1'b1;
            end
            ST_WAIT: begin
                if (mem_valid) begin
                    if (flush || squash) begin
                        squash_d = 1'b0;
                        state_d  = ST_REQ;
                    end else if (!stall) begin
                        accept    = 1'b1;
                        acc_instr = mem_rdata;
                        acc_pc2   = mem_addr + 16'd2;
                    end else begin
                        hold_instr_d = mem_rdata;
                        hold_pc2_d   = mem_addr + 16'd2;
                        state_d      = ST_HOLD;
                    end
                end else if (flush) begin
                    squash_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (flush)       state_d = ST_REQ;
                else if (!stall) accept  = 1'b1;
            end
            ST_HALT: begin
                if (flush) begin
                    state_d  = ST_REQ;
                    halted_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            instr_d      = acc_instr;
            pc2_d        = acc_pc2;
            valid_d      = 1'b1;
            pc_advance_d = 1'b1;
            if (acc_instr[15:12] == HALT_OP) begin
                state_d  = ST_HALT;
                halted_d = 1'b1;
            end else begin
                state_d  = ST_REQ;
            end
        end

        if (flush && state != ST_IDLE) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= ST_IDLE;
            squash         <= 1'b0;
            hold_instr     <= NOP_INSTR;
            hold_pc2       <= '0;
            mem_req        <= 1'b0;
            mem_addr       <= '0;
            pc_advance     <= 1'b0;
            if_id_instr    <= NOP_INSTR;
            if_id_pc_plus2 <= '0;
            if_id_valid    <= 1'b0;
            halted         <= 1'b0;
        end else begin
            state          <= state_d;
            squash         <= squash_d;
            hold_instr     <= hold_instr_d;
            hold_pc2       <= hold_pc2_d;
            mem_req        <= mem_req_d;
            mem_addr       <= mem_addr_d;
            pc_advance     <= pc_advance_d;
            if_id_instr    <= instr_d;
            if_id_pc_plus2 <= pc2_d;
            if_id_valid    <= valid_d;
            halted         <= halted_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, straight fetch, stall/hold, flush
// in WAIT, HALT and recovery, PC+2 wrap and mid-fetch reset.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc_in;
    logic        stall;
    logic        flush;
    logic [15:0] mem_rdata;
    logic        mem_valid;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        pc_advance;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc_plus2;
    logic        if_id_valid;
    logic        halted;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    fetch_unit #(.HALT_OP(4'hF), .NOP_INSTR(16'h0000)) dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .stall(stall), .flush(flush),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid), .mem_req(mem_req),
        .mem_addr(mem_addr), .pc_advance(pc_advance), .if_id_instr(if_id_instr),
        .if_id_pc_plus2(if_id_pc_plus2), .if_id_valid(if_id_valid), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_ifid(input string tag, input logic [15:0] ins, input logic [15:0] pc2,
                            input logic v, input logic adv);
        chk({tag, ".instr"}, if_id_instr, ins);
        chk({tag, ".pc2"},   if_id_pc_plus2, pc2);
        chk({tag, ".valid"}, {15'd0, if_id_valid}, {15'd0, v});
        chk({tag, ".adv"},   {15'd0, pc_advance}, {15'd0, adv});
    endtask

    task automatic chk_reset(input string tag);
        chk_ifid(tag, 16'h0000, 16'h0000, 1'b0, 1'b0);
        chk({tag, ".req"},    {15'd0, mem_req}, 16'd0);
        chk({tag, ".addr"},   mem_addr, 16'h0000);
        chk({tag, ".halted"}, {15'd0, halted}, 16'd0);
    endtask

    initial begin
        rst = 1'b0; pc_in = 16'h0000; stall = 1'b0; flush = 1'b0;
        mem_rdata = 16'h0000; mem_valid = 1'b1;

        // 1: reset with a spurious mem_valid
        tick(); tick();
        chk_reset("reset");

        // 2: straight fetch from 0x0010
        rst = 1'b1; mem_valid = 1'b0; pc_in = 16'h0010;
        tick();                                  // IDLE -> REQ
        chk("idle.req", {15'd0, mem_req}, 16'd0);
        tick();                                  // REQ issues
        chk("f1.req", {15'd0, mem_req}, 16'd1);
        chk("f1.addr", mem_addr, 16'h0010);
        mem_valid = 1'b1; mem_rdata = 16'h1234;
        tick();                                  // accept
        chk_ifid("f1.load", 16'h1234, 16'h0012, 1'b1, 1'b1);
        chk("f1.req_lo", {15'd0, mem_req}, 16'd0);
        mem_valid = 1'b0; pc_in = 16'h0020;
        tick();                                  // REQ issues next
        chk("f2.adv_pulse", {15'd0, pc_advance}, 16'd0);
        chk("f2.req", {15'd0, mem_req}, 16'd1);
        chk("f2.addr", mem_addr, 16'h0020);
        chk("f2.instr_keep", if_id_instr, 16'h1234);

        // 3: stall when response arrives
        stall = 1'b1; mem_valid = 1'b1; mem_rdata = 16'hA5A5;
        tick();                                  // -> HOLD
        chk_ifid("stall1", 16'h1234, 16'h0012, 1'b1, 1'b0);
        chk("stall1.req", {15'd0, mem_req}, 16'd0);
        mem_valid = 1'b0; mem_rdata = 16'h0000;
        tick();                                  // still HOLD
        chk_ifid("stall2", 16'h1234, 16'h0012, 1'b1, 1'b0);
        chk("stall2.req", {15'd0, mem_req}, 16'd0);
        stall = 1'b0;
        tick();                                  // release from hold buffer
        chk_ifid("release", 16'hA5A5, 16'h0022, 1'b1, 1'b1);
        pc_in = 16'h0030;
        tick();
        chk("f3.req", {15'd0, mem_req}, 16'd1);
        chk("f3.addr", mem_addr, 16'h0030);
        chk("f3.adv_pulse", {15'd0, pc_advance}, 16'd0);

        // 4: flush while waiting, response must be dropped
        flush = 1'b1;
        tick();
        chk_ifid("flushw", 16'h0000, 16'h0022, 1'b0, 1'b0);
        chk("flushw.req", {15'd0, mem_req}, 16'd0);
        flush = 1'b0; mem_valid = 1'b1; mem_rdata = 16'hBEEF; pc_in = 16'h0040;
        tick();                                  // squashed response
        chk_ifid("squash", 16'h0000, 16'h0022, 1'b0, 1'b0);
        mem_valid = 1'b0;
        tick();
        chk("f4.req", {15'd0, mem_req}, 16'd1);
        chk("f4.addr", mem_addr, 16'h0040);

        // 5: HALT
        mem_valid = 1'b1; mem_rdata = 16'hF000;
        tick();
        chk_ifid("halt", 16'hF000, 16'h0042, 1'b1, 1'b1);
        chk("halt.halted", {15'd0, halted}, 16'd1);
        mem_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("halt.noreq", {15'd0, mem_req}, 16'd0);
        end
        chk("halt.still", {15'd0, halted}, 16'd1);
        chk("halt.adv", {15'd0, pc_advance}, 16'd0);
        pc_in = 16'h0050; flush = 1'b1;
        tick();                                  // HALT -> REQ
        chk("unhalt.halted", {15'd0, halted}, 16'd0);
        chk_ifid("unhalt", 16'h0000, 16'h0042, 1'b0, 1'b0);
        flush = 1'b0;
        tick();
        chk("f5.req", {15'd0, mem_req}, 16'd1);
        chk("f5.addr", mem_addr, 16'h0050);

        // 6: wrap of PC+2, then reset mid-WAIT
        mem_valid = 1'b1; mem_rdata = 16'h1111; pc_in = 16'hFFFE;
        tick();
        chk_ifid("f6.load", 16'h1111, 16'h0052, 1'b1, 1'b1);
        mem_valid = 1'b0;
        tick();
        chk("wrap.addr", mem_addr, 16'hFFFE);
        mem_valid = 1'b1; mem_rdata = 16'h2222;
        tick();
        chk_ifid("wrap", 16'h2222, 16'h0000, 1'b1, 1'b1);
        mem_valid = 1'b0;
        tick();                                  // new request, now in WAIT
        chk("wrap2.req", {15'd0, mem_req}, 16'd1);
        rst = 1'b0;
        tick();
        chk_reset("midreset");
        rst = 1'b1; mem_valid = 1'b1; mem_rdata = 16'h3333;
        tick();                                  // IDLE: late response ignored
        chk_ifid("late", 16'h0000, 16'h0000, 1'b0, 1'b0);
        chk("late.req", {15'd0, mem_req}, 16'd0);
        mem_valid = 1'b0;
        tick();
        chk("after.req", {15'd0, mem_req}, 16'd1);
        chk("after.addr", mem_addr, 16'hFFFE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
